// File: rtl/mul_pkg.sv
// Shared types for the sequential RV32M multiplier: opcode and FSM state
// encodings plus the per-opcode operand signedness rules.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,  // MUL    : low half,  signed x signed
    MUL_HSS = 2'b01,  // MULH   : high half, signed x signed
    MUL_HSU = 2'b10,  // MULHSU : high half, signed x unsigned
    MUL_HUU = 2'b11   // MULHU  : high half, unsigned x unsigned
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  // rs1 is signed for every opcode except MULHU.
  function automatic logic op_a_signed(input mul_op_e op);
    return op != MUL_HUU;
  endfunction

  // rs2 is signed only for MUL and MULH.
  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MUL_LO) || (op == MUL_HSS);
  endfunction

endpackage

// File: rtl/multiplier_seq_step.sv
// One shift-add step: adds (shifted |a|) x (BPC-bit digit of |b|) to the
// running 2*WIDTH-bit accumulator. Purely combinational.
module multiplier_seq_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 2
) (
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [BPC-1:0]     digit,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] partial;

  // Partial product as a sum of shifted copies of the multiplicand, one per set digit bit.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BPC; j++) begin
      if (digit[j]) partial = partial + (mcand << j);
    end
    acc_next = acc + partial;
  end

endmodule

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier for the RV32M execute lane (MUL, MULH,
// MULHSU, MULHU). Retires BPC multiplier bits per CALC cycle, one operation
// in flight, valid/ready on both sides, flushable.
// Optional feature: define MUL_EARLY_OUT_EN to leave CALC as soon as the
// remaining multiplier magnitude is zero (and skip CALC when |b| is zero).
module multiplier_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_e         state_q, state_d;
  mul_op_e            op_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] mcand_q;   // |a| pre-shifted to the current digit position
  logic [WIDTH-1:0]   b_mag_q;   // unretired multiplier bits, LSB = current digit
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;

  mul_op_e            op_in;
  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in, b_rest;
  logic [2*WIDTH-1:0] acc_next, product;

  // Operand conditioning at the accept edge: magnitudes plus product sign.
  // The magnitude of -2^(WIDTH-1) is exactly 2^(WIDTH-1) as an unsigned value.
  always_comb begin
    op_in    = mul_op_e'(i_op);
    a_neg    = op_a_signed(op_in) & i_a[WIDTH-1];
    b_neg    = op_b_signed(op_in) & i_b[WIDTH-1];
    a_mag_in = a_neg ? -i_a : i_a;
    b_mag_in = b_neg ? -i_b : i_b;
    accept   = (state_q == IDLE) & i_valid & ~i_flush;
    b_rest   = b_mag_q >> BPC;
    product  = neg_q ? -acc_q : acc_q;
  end

  multiplier_seq_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_step (
    .mcand    (mcand_q),
    .digit    (b_mag_q[BPC-1:0]),
    .acc      (acc_q),
    .acc_next (acc_next)
  );

  // Next-state logic; flush overrides every transition, including accept and handoff.
  // NOTE: state_d gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MUL_EARLY_OUT_EN
          state_d = (b_mag_in == '0) ? SIGN : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt_q == CNT_ONE) begin
          state_d = SIGN;
        end
`ifdef MUL_EARLY_OUT_EN
        else if (b_rest == '0) begin
          state_d = SIGN;
        end
`endif
      end
      SIGN:    state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  // State register; reset wins over flush because it is tested first.
  // NOTE: sequential blocks use <= so every register sees pre-edge values of its peers.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: load on accept, shift-add in CALC, sign fix and half select in SIGN.
  // NOTE: every datapath register is cleared on reset; o_result must read 0 afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q     <= MUL_LO;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      neg_q   <= a_neg ^ b_neg;
      mcand_q <= {{WIDTH{1'b0}}, a_mag_in};
      b_mag_q <= b_mag_in;
      acc_q   <= '0;
      cnt_q   <= CNT_INIT;
    end else if (state_q == CALC) begin
      acc_q   <= acc_next;
      mcand_q <= mcand_q << BPC;
      b_mag_q <= b_rest;
      cnt_q   <= cnt_q - CNT_ONE;
    end else if ((state_q == SIGN) && !i_flush) begin
      result_q <= (op_q == MUL_LO) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;

endmodule
